// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and the frame-length helper shared by the UART receiver files.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, PARITY} state_t;
    function automatic int frame_bits(input int data_w, input bit parity);
        return data_w + 2 + int'(parity);
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, word handshake and status of the receiver.
// UART_RX_PARITY_EN adds the odd select and the parity_err flag.
interface uart_rx_if #(parameter int DATA_W = 8);
    logic              rxd;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              busy;
    logic              idle;
    logic              frame_err;
    logic              overrun;
    logic              clr_err;
`ifdef UART_RX_PARITY_EN
    logic              odd;
    logic              parity_err;
    modport slave (input rxd, ready, clr_err, odd,
                   output data, valid, busy, idle, frame_err, overrun, parity_err);
    modport master (output rxd, ready, clr_err, odd,
                    input data, valid, busy, idle, frame_err, overrun, parity_err);
`else
    modport slave (input rxd, ready, clr_err,
                   output data, valid, busy, idle, frame_err, overrun);
    modport master (output rxd, ready, clr_err,
                    input data, valid, busy, idle, frame_err, overrun);
`endif
endinterface

// File: rtl/uart_sync.sv
// uart_sync: SYNC_STAGES-deep rxd synchroniser preset to the idle-high level, with falling-edge detect.
module uart_sync #(parameter int SYNC_STAGES = 2) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic d,
    output logic q,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sr;
    logic                   prev;
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            sr   <= '1;
            prev <= 1'b1;
        end else begin
            sr   <= {sr[SYNC_STAGES-2:0], d};
            prev <= sr[SYNC_STAGES-1];
        end
    assign q    = sr[SYNC_STAGES-1];
    assign fall = prev & ~q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver with valid/ready output register and sticky error flags.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_W       = 8,
    parameter int SYNC_STAGES  = 2
) (
    input logic      i_clk,
    input logic      i_reset,
    uart_rx_if.slave bus
);
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int IDLE_MAX = frame_bits(DATA_W, PAR) * CLKS_PER_BIT;
    localparam int DW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_W);
    localparam int IW = $clog2(IDLE_MAX + 1);
    localparam logic [DW-1:0] HALF = DW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DW-1:0] FULL = DW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic [IW-1:0] IMAX = IW'(IDLE_MAX);

    state_t            state, state_n;
    logic [DW-1:0]     div, div_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     icnt, icnt_n;
    logic [DATA_W-1:0] sh, sh_n, data_r, data_n;
    logic              valid_r, valid_n, busy_r, busy_n, ferr_r, ferr_n, ovr_r, ovr_n;
    logic              rx_s, fall, expire, done;
`ifdef UART_RX_PARITY_EN
    logic              perr_r, perr_n;
`endif

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk(i_clk), .i_reset(i_reset), .d(bus.rxd), .q(rx_s), .fall(fall)
    );

    always_comb begin
        expire  = div == '0;
        done    = 1'b0;
        state_n = state;
        div_n   = expire ? div : div - 1'b1;
        cnt_n   = cnt;
        sh_n    = sh;
        data_n  = data_r;
        valid_n = valid_r & ~bus.ready;
        ferr_n  = ferr_r & ~bus.clr_err;
        ovr_n   = ovr_r & ~bus.clr_err;
`ifdef UART_RX_PARITY_EN
        perr_n  = perr_r & ~bus.clr_err;
`endif
        case (state)
            IDLE: if (fall) begin
                state_n = START;
                div_n   = HALF;
                cnt_n   = '0;
            end
            START: if (expire) begin
                state_n = rx_s ? IDLE : DATA;
                div_n   = FULL;
            end
            DATA: if (expire) begin
                sh_n    = {rx_s, sh[DATA_W-1:1]};
                div_n   = FULL;
                cnt_n   = cnt == LAST ? '0 : cnt + 1'b1;
                state_n = cnt == LAST ? (PAR ? PARITY : STOP) : DATA;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (expire) begin
                div_n   = FULL;
                state_n = STOP;
                perr_n  = perr_n | ((^sh ^ rx_s) != bus.odd);
            end
`endif
            STOP: if (expire) begin
                state_n = rx_s ? IDLE : BREAK;
                done    = rx_s;
                ferr_n  = ferr_n | ~rx_s;
            end
            BREAK: state_n = rx_s ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
        // an unaccepted word is kept; a same-cycle accept lets the new one replace it
        if (done) begin
            ovr_n   = ovr_n | (valid_r & ~bus.ready);
            data_n  = valid_r & ~bus.ready ? data_r : sh_n;
            valid_n = 1'b1;
        end
        icnt_n = !rx_s ? '0 : icnt == IMAX ? icnt : icnt + 1'b1;
        busy_n = state_n != IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            state   <= IDLE;
            div     <= '0;
            cnt     <= '0;
            icnt    <= '0;
            sh      <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_r  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            div     <= div_n;
            cnt     <= cnt_n;
            icnt    <= icnt_n;
            sh      <= sh_n;
            data_r  <= data_n;
            valid_r <= valid_n;
            busy_r  <= busy_n;
            ferr_r  <= ferr_n;
            ovr_r   <= ovr_n;
`ifdef UART_RX_PARITY_EN
            perr_r  <= perr_n;
`endif
        end

    assign bus.data      = data_r;
    assign bus.valid     = valid_r;
    assign bus.busy      = busy_r;
    assign bus.idle      = icnt == IMAX;
    assign bus.frame_err = ferr_r;
    assign bus.overrun   = ovr_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_r;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against an event-level model of the receiver outputs.
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 87;
`else
    localparam int LAT = 79;
`endif
    typedef struct {int at; logic [7:0] w; bit ok; bit pe;} ev_t;

    logic clk = 1'b0;
    logic i_reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  evq[$];
    logic m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;
    logic [7:0] m_data = 8'h00;

    uart_rx_if #(.DATA_W(8)) bus ();
    uart_rx #(.CLKS_PER_BIT(8), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_reset(i_reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame completions are scheduled by the driver; the model applies the handshake rules at that edge.
    always @(posedge clk) begin : model
        ev_t e;
        bit done, fe, pe;
        done = 1'b0; fe = 1'b0; pe = 1'b0;
        e = '{0, 8'h00, 1'b0, 1'b0};
        if (!i_reset) begin
            evq.delete();
            m_valid <= 1'b0; m_data <= 8'h00; m_ovr <= 1'b0; m_ferr <= 1'b0; m_perr <= 1'b0;
        end else begin
            if (evq.size() > 0) begin
                pe = evq[0].pe && (evq[0].at - 8 == cyc + 1);
                if (evq[0].at == cyc + 1) begin
                    e = evq.pop_front();
                    done = e.ok;
                    fe = !e.ok;
                end
            end
            if (done && !(m_valid && !bus.ready)) begin
                m_data <= e.w;
                m_valid <= 1'b1;
            end else if (m_valid && bus.ready) m_valid <= 1'b0;
            m_ovr  <= (m_ovr && !bus.clr_err) || (done && m_valid && !bus.ready);
            m_ferr <= (m_ferr && !bus.clr_err) || fe;
            m_perr <= (m_perr && !bus.clr_err) || pe;
        end
    end

    always @(negedge clk) if (i_reset) begin
        chk("valid", 32'(bus.valid), 32'(m_valid));
        if (m_valid) chk("data", 32'(bus.data), 32'(m_data));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
`ifdef UART_RX_PARITY_EN
        chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input bit stop, input bit badpar);
        bit pb;
        pb = 1'b0;
`ifdef UART_RX_PARITY_EN
        pb = ^w ^ bus.odd ^ badpar;
        evq.push_back('{cyc + LAT, w, stop, badpar});
`else
        evq.push_back('{cyc + LAT, w, stop, 1'b0});
`endif
        bus.rxd = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = w[i];
            tick(8);
        end
`ifdef UART_RX_PARITY_EN
        bus.rxd = pb;
        tick(8);
`endif
        bus.rxd = stop;
        tick(8);
    endtask

    task automatic wait_valid(input int k0, output int lat, output logic [7:0] d);
        lat = -1;
        d = 8'h00;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            tick(1);
            if (bus.valid) begin
                lat = cyc - k0;
                d = bus.data;
            end
        end
    endtask

    task automatic recv(input logic [7:0] w, input bit badpar, input string nm);
        int k0, lat;
        logic [7:0] d;
        k0 = cyc;
        fork
            send(w, 1'b1, badpar);
            wait_valid(k0, lat, d);
        join
        chk({nm, " latency"}, 32'(lat), 32'(LAT));
        chk({nm, " data"}, 32'(d), 32'(w));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        bus.rxd = 1'b1; bus.ready = 1'b0; bus.clr_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        bus.odd = 1'b0;
`endif
        tick(3);
        chk("reset outputs", 32'({bus.valid, bus.busy, bus.idle, bus.frame_err, bus.overrun, bus.data}), 32'h0);
        i_reset = 1'b1;
        tick(100);
        chk("idle after quiet line", 32'(bus.idle), 32'h1);

        // 1: single word, consumer ready
        bus.ready = 1'b1;
        recv(8'h55, 1'b0, "t1 0x55");
        chk("t1 frame_err", 32'(bus.frame_err), 32'h0);
        tick(1);
        chk("t1 valid single pulse", 32'(bus.valid), 32'h0);

        // 2: two words, nobody reading
        bus.ready = 1'b0;
        send(8'hA3, 1'b1, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        tick(2);
        chk("t2 held data", 32'(bus.data), 32'hA3);
        chk("t2 overrun", 32'(bus.overrun), 32'h1);
        bus.ready = 1'b1;
        tick(1);
        chk("t2 valid drop", 32'(bus.valid), 32'h0);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        chk("t2 overrun cleared", 32'(bus.overrun), 32'h0);

        // 3: 3-cycle glitch is a false start
        tick(20);
        nb = 0;
        bus.rxd = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) bus.rxd = 1'b1;
            tick(1);
            if (bus.busy) nb++;
        end
        chk("t3 busy span ok", 32'(nb >= 1 && nb <= 5), 32'h1);
        chk("t3 no valid", 32'(bus.valid), 32'h0);
        chk("t3 idle reset by glitch", 32'(bus.idle), 32'h0);

        // 4: stop bit low, line held low, then a clean frame
        send(8'h81, 1'b0, 1'b0);
        tick(40);
        chk("t4 frame_err", 32'(bus.frame_err), 32'h1);
        chk("t4 busy in break", 32'(bus.busy), 32'h1);
        chk("t4 no valid", 32'(bus.valid), 32'h0);
        bus.rxd = 1'b1;
        tick(5);
        chk("t4 break exit", 32'(bus.busy), 32'h0);
        tick(10);
        recv(8'h42, 1'b0, "t4 0x42");
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        chk("t4 frame_err cleared", 32'(bus.frame_err), 32'h0);

        // 5: reset in the middle of a frame with a word pending
        bus.ready = 1'b0;
        tick(10);
        send(8'h99, 1'b1, 1'b0);
        tick(2);
        chk("t5 pending valid", 32'(bus.valid), 32'h1);
        fork
            send(8'hFF, 1'b1, 1'b0);
            begin
                tick(30);
                chk("t5 busy mid data", 32'(bus.busy), 32'h1);
                #1 i_reset = 1'b0;
                #1 chk("t5 async reset outputs",
                       32'({bus.valid, bus.busy, bus.idle, bus.frame_err, bus.overrun, bus.data}), 32'h0);
                tick(2);
                i_reset = 1'b1;
            end
        join
        bus.ready = 1'b1;
        tick(20);
        recv(8'h3C, 1'b0, "t5 0x3C");

`ifdef UART_RX_PARITY_EN
        // 6: even parity expected, parity bit 0 for 0x07 is wrong
        tick(10);
        recv(8'h07, 1'b1, "t6 0x07");
        chk("t6 parity_err", 32'(bus.parity_err), 32'h1);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        chk("t6 parity_err cleared", 32'(bus.parity_err), 32'h0);
`endif
        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
